// File: rtl/car_cmd_responder.sv
// Simulator-side responder for the car-control UART link: decodes 8N1 command
// bytes into motion/barrier controls and periodically reports detector status.
module car_cmd_responder #(
  parameter int CLKS_PER_BIT  = 10417,
  parameter int STATUS_PERIOD = 1000000,
  parameter int TIMEOUT_CLKS  = 50000000
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic rxd,
  output logic txd,
  input  logic front_det,
  input  logic back_det,
  input  logic left_det,
  input  logic right_det,
  output logic move_forward,
  output logic move_backward,
  output logic turn_left,
  output logic turn_right,
  output logic place_barrier,
  output logic destroy_barrier,
  output logic cmd_valid,
  output logic hdr_err,
  output logic frame_err
);

  localparam int BIT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int PER_W = $clog2(STATUS_PERIOD + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // RX state
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [BIT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [5:0]       cmd_q, cmd_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             hdr_err_q, hdr_err_d;
  logic             frame_err_q, frame_err_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic             byte_done;
  logic [5:0]       cmd_decoded;

  // TX state
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic             pending_q, pending_d;
  logic             tick;
  tx_state_e        tx_state_q, tx_state_d;
  logic [BIT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             txd_q, txd_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      hdr_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      wd_cnt_q    <= '0;
    end else begin
      rx_meta_q   <= rxd;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      hdr_err_q   <= hdr_err_d;
      frame_err_q <= frame_err_d;
      wd_cnt_q    <= wd_cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a signal unassigned, which would infer a latch.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + BIT_W'(1);
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    byte_done   = 1'b0;
    frame_err_d = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            byte_done  = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            rx_state_d  = RX_WAIT_IDLE;
          end
        end
      end
      RX_WAIT_IDLE: begin
        rx_cnt_d = '0;
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Conflicting direction pairs cancel; barrier bits pass straight through.
  assign cmd_decoded = {rx_shift_q[5], rx_shift_q[4],
                        rx_shift_q[3] & ~rx_shift_q[2], rx_shift_q[2] & ~rx_shift_q[3],
                        rx_shift_q[1] & ~rx_shift_q[0], rx_shift_q[0] & ~rx_shift_q[1]};

  always_comb begin
    cmd_valid_d = byte_done && (rx_shift_q[7:6] == 2'b10);
    hdr_err_d   = byte_done && (rx_shift_q[7:6] != 2'b10);
    cmd_d       = cmd_q;
    wd_cnt_d    = wd_cnt_q;
    if (cmd_valid_d) begin
      cmd_d    = cmd_decoded;
      wd_cnt_d = '0;
    end else if (wd_cnt_q != WD_W'(TIMEOUT_CLKS)) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
      // Outputs drop in the same cycle the counter lands on the limit.
      if (wd_cnt_q == WD_W'(TIMEOUT_CLKS - 1)) cmd_d = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      per_cnt_q  <= '0;
      pending_q  <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      per_cnt_q  <= per_cnt_d;
      pending_q  <= pending_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  assign tick      = (per_cnt_q == PER_W'(STATUS_PERIOD - 1));
  assign per_cnt_d = tick ? '0 : per_cnt_q + PER_W'(1);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + BIT_W'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    pending_d  = pending_q | tick;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (pending_q) begin
          // A tick landing on this same cycle keeps the flag for one more frame.
          pending_d  = tick;
          tx_shift_d = {4'b0000, right_det, left_det, back_det, front_det};
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end
      end
    endcase

    // txd is registered from the next state so the line never glitches.
    unique case (tx_state_d)
      TX_IDLE:  txd_d = 1'b1;
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_shift_d[0];
      TX_STOP:  txd_d = 1'b1;
    endcase
  end

  assign txd             = txd_q;
  assign move_forward    = cmd_q[0];
  assign move_backward   = cmd_q[1];
  assign turn_left       = cmd_q[2];
  assign turn_right      = cmd_q[3];
  assign place_barrier   = cmd_q[4];
  assign destroy_barrier = cmd_q[5];
  assign cmd_valid       = cmd_valid_q;
  assign hdr_err         = hdr_err_q;
  assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_car_cmd_responder.sv
// Scoreboard bench for car_cmd_responder: each driven frame queues its expected
// pulse/outputs, a negedge monitor pops and compares; TX frames decoded bit-by-bit.
module tb_car_cmd_responder;

  localparam int CPB = 16;
  localparam int PER = 400;
  localparam int TMO = 2000;
  // Start edge to visible pulse: 2 sync flops + edge flop + half bit + 8 bits + stop.
  localparam int PULSE_LAT = 3 + CPB / 2 + 8 * CPB + CPB;

  logic sys_clk;
  logic rst;
  logic rxd, txd;
  logic front_det, back_det, left_det, right_det;
  logic move_forward, move_backward, turn_left, turn_right;
  logic place_barrier, destroy_barrier;
  logic cmd_valid, hdr_err, frame_err;
  logic [5:0] outs;

  car_cmd_responder #(
    .CLKS_PER_BIT (CPB),
    .STATUS_PERIOD(PER),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .rxd            (rxd),
    .txd            (txd),
    .front_det      (front_det),
    .back_det       (back_det),
    .left_det       (left_det),
    .right_det      (right_det),
    .move_forward   (move_forward),
    .move_backward  (move_backward),
    .turn_left      (turn_left),
    .turn_right     (turn_right),
    .place_barrier  (place_barrier),
    .destroy_barrier(destroy_barrier),
    .cmd_valid      (cmd_valid),
    .hdr_err        (hdr_err),
    .frame_err      (frame_err)
  );

  assign outs = {destroy_barrier, place_barrier, turn_right, turn_left, move_backward, move_forward};

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // kind: 0 = cmd_valid, 1 = hdr_err, 2 = frame_err
  typedef struct {
    int         kind;
    logic [5:0] outs;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] model_outs = '0;
  int         last_pulse_cyc = 0;
  int         mon_kind;
  exp_t       mon_e;

  function automatic logic [5:0] decode(input logic [7:0] b);
    return {b[5], b[4], b[3] & ~b[2], b[2] & ~b[3], b[1] & ~b[0], b[0] & ~b[1]};
  endfunction

  always @(negedge sys_clk) begin
    if (cmd_valid || hdr_err || frame_err) begin
      mon_kind = cmd_valid ? 0 : (hdr_err ? 1 : 2);
      if (exp_q.size() == 0) begin
        check("spurious_pulse", {29'd0, cmd_valid, hdr_err, frame_err}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind", mon_kind, mon_e.kind);
        check("pulse_cycle", cyc, mon_e.cyc);
        check("pulse_one_hot", $countones({cmd_valid, hdr_err, frame_err}), 1);
        check("pulse_outputs", {26'd0, outs}, {26'd0, mon_e.outs});
        last_pulse_cyc = cyc;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    exp_t e;
    if (bad_stop) begin
      e.kind = 2;
    end else if (b[7:6] == 2'b10) begin
      e.kind     = 0;
      model_outs = decode(b);
    end else begin
      e.kind = 1;
    end
    e.outs = model_outs;
    e.cyc  = cyc + PULSE_LAT;
    exp_q.push_back(e);
    rxd = 1'b0;
    repeat (CPB) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge sys_clk);
    end
    rxd = !bad_stop;
    repeat (CPB) @(negedge sys_clk);
    rxd = 1'b1;
    repeat (4) @(negedge sys_clk);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic wait_tx_start(output int t, output bit ok);
    logic prev;
    prev = txd;
    ok   = 1'b0;
    t    = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge sys_clk);
      if (prev && !txd) begin
        ok = 1'b1;
        t  = cyc;
      end
      prev = txd;
    end
    check("tx_start_seen", {31'd0, ok}, 32'd1);
  endtask

  // Called on the negedge of the first start-bit cycle; each bit must hold 16 samples.
  task automatic check_tx_frame(input logic [7:0] data, input bit toggle);
    for (int b = 0; b < 10; b++) begin
      logic exp_bit;
      int   good;
      good    = 0;
      exp_bit = (b == 0) ? 1'b0 : ((b == 9) ? 1'b1 : data[b-1]);
      if (toggle && b == 3) begin
        back_det = 1'b1;
        left_det = 1'b1;
      end
      if (toggle && b == 8) begin
        back_det = 1'b0;
        left_det = 1'b0;
      end
      for (int s = 0; s < CPB; s++) begin
        if (txd === exp_bit) good++;
        @(negedge sys_clk);
      end
      check($sformatf("tx_bit%0d_cycles", b), good, CPB);
    end
  endtask

  int t1, t2, t3;
  bit ok1, ok2, ok3;
  int p;

  initial begin
    rst       = 1'b1;
    rxd       = 1'b1;
    front_det = 1'b0;
    back_det  = 1'b0;
    left_det  = 1'b0;
    right_det = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("reset_txd", txd, 1);
    check("reset_outs", {26'd0, outs}, 0);
    check("reset_pulses", {cmd_valid, hdr_err, frame_err}, 0);
    repeat (3) @(negedge sys_clk);
    rst = 1'b1;
    repeat (5) @(negedge sys_clk);

    // 1: full command with barrier bits
    send_byte(8'hB5, 1'b0);
    check("t1_outs", {26'd0, outs}, 32'h35);

    // 2: valid then bad header
    send_byte(8'h81, 1'b0);
    check("t2_fwd", {26'd0, outs}, 32'h01);
    send_byte(8'h23, 1'b0);
    check("t2_hold", {26'd0, outs}, 32'h01);

    // 3: conflicting pairs
    send_byte(8'h83, 1'b0);
    check("t3_fb_cancel", {26'd0, outs}, 32'h00);
    send_byte(8'h8C, 1'b0);
    check("t3_lr_cancel", {26'd0, outs}, 32'h00);
    send_byte(8'hBF, 1'b0);
    check("t3_all_set", {26'd0, outs}, 32'h30);

    // 4: framing error discards the byte
    send_byte(8'h81, 1'b1);
    check("t4_hold", {26'd0, outs}, 32'h30);
    repeat (10) @(negedge sys_clk);
    send_byte(8'h82, 1'b0);
    check("t4_back", {26'd0, outs}, 32'h02);

    // 5: status frames
    front_det = 1'b1;
    right_det = 1'b1;
    @(negedge sys_clk);
    wait_tx_start(t1, ok1);
    if (ok1) check_tx_frame(8'h09, 1'b1);
    wait_tx_start(t2, ok2);
    if (ok2) begin
      check("tx_period", t2 - t1, PER);
      check_tx_frame(8'h09, 1'b0);
    end

    // 6: watchdog
    send_byte(8'h81, 1'b0);
    p = last_pulse_cyc;
    while (cyc < p + TMO - 1) @(negedge sys_clk);
    check("wd_before_timeout", move_forward, 1);
    @(negedge sys_clk);
    check("wd_at_timeout", {26'd0, outs}, 0);
    model_outs = '0;
    repeat (300) @(negedge sys_clk);
    check("wd_stays_low", {26'd0, outs}, 0);

    // 6: reset mid RX and mid TX frame
    send_byte(8'h84, 1'b0);
    check("t6_left", {26'd0, outs}, 32'h04);
    wait_tx_start(t3, ok3);
    rxd = 1'b0;
    repeat (6) @(negedge sys_clk);
    check("tx_low_before_reset", txd, 0);
    rst = 1'b0;
    #1;
    check("midreset_txd", txd, 1);
    check("midreset_outs", {26'd0, outs}, 0);
    check("midreset_pulses", {cmd_valid, hdr_err, frame_err}, 0);
    model_outs = '0;
    repeat (3) @(negedge sys_clk);
    rxd = 1'b1;
    repeat (3) @(negedge sys_clk);
    rst = 1'b1;
    repeat (200) @(negedge sys_clk);
    check("post_reset_outs", {26'd0, outs}, 0);
    check("post_reset_no_pulse", exp_q.size(), 0);
    send_byte(8'h82, 1'b0);
    check("post_reset_cmd", {26'd0, outs}, 32'h02);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
